// File: rtl/shared_mem_ctrl.sv
// Shared-memory responder: round-robin arbitration across core request ports,
// one load/store per grant against a local array, one-cycle completion pulse.
module shared_mem_ctrl #(
  parameter int NUM_CORES = 4,
  parameter int ID_W      = 2,
  parameter int ADDR_W    = 12,
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 4096
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_CORES-1:0]        mem_req,
  input  logic [NUM_CORES-1:0]        mem_we,
  input  logic [NUM_CORES*ADDR_W-1:0] mem_addr,
  input  logic [NUM_CORES*DATA_W-1:0] mem_wdata,
  output logic [NUM_CORES-1:0]        val_data,
  output logic [DATA_W-1:0]           mem_dat,
  output logic                        busy,
  output logic [ID_W-1:0]             grant_id
);

  typedef enum logic [1:0] {IDLE, ACCESS, RELEASE} state_t;

  state_t            state;
  logic [ID_W-1:0]   ptr;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic [DATA_W-1:0] mem_array [DEPTH];

  logic              win_found;
  logic [ID_W-1:0]   win_id;
  logic [ID_W-1:0]   scan_id;
  logic [ID_W-1:0]   ptr_next;
  logic              win_we;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_wdata;
  int                scan_idx;

  // Scan from ptr upward, wrapping; the first requester found owns the next grant.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    scan_idx  = 0;
    scan_id   = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      scan_idx = (int'(ptr) + i) % NUM_CORES;
      scan_id  = ID_W'(scan_idx);
      if (!win_found && mem_req[scan_id]) begin
        win_found = 1'b1;
        win_id    = scan_id;
      end
    end
    win_we    = mem_we[win_id];
    win_addr  = mem_addr[int'(win_id)*ADDR_W +: ADDR_W];
    win_wdata = mem_wdata[int'(win_id)*DATA_W +: DATA_W];
    ptr_next  = (int'(win_id) == NUM_CORES - 1) ? '0 : win_id + ID_W'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      ptr       <= '0;
      grant_id  <= '0;
      val_data  <= '0;
      mem_dat   <= '0;
      req_we    <= 1'b0;
      req_addr  <= '0;
      req_wdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (win_found) begin
            grant_id  <= win_id;
            req_we    <= win_we;
            req_addr  <= win_addr;
            req_wdata <= win_wdata;
            ptr       <= ptr_next;
            state     <= ACCESS;
          end
        end
        ACCESS: begin
          if (!req_we) begin
            mem_dat <= mem_array[req_addr];
          end
          val_data <= NUM_CORES'(1) << grant_id;
          state    <= RELEASE;
        end
        RELEASE: begin
          // Hold the grant until the owner lets go, so nobody else slips in.
          val_data <= '0;
          if (!mem_req[grant_id]) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Array is never cleared; reset forces IDLE so an in-flight store is dropped.
  always_ff @(posedge clk) begin
    if (state == ACCESS && req_we) begin
      mem_array[req_addr] <= req_wdata;
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_shared_mem_ctrl.sv
// Directed bench for shared_mem_ctrl with a transaction-level reference model
// compared against the DUT every cycle.
module tb_shared_mem_ctrl;

  localparam int NUM_CORES = 4;
  localparam int ID_W      = 2;
  localparam int ADDR_W    = 12;
  localparam int DATA_W    = 8;
  localparam int DEPTH     = 4096;

  logic                        clk = 1'b0;
  logic                        reset;
  logic [NUM_CORES-1:0]        mem_req;
  logic [NUM_CORES-1:0]        mem_we;
  logic [NUM_CORES*ADDR_W-1:0] mem_addr;
  logic [NUM_CORES*DATA_W-1:0] mem_wdata;
  logic [NUM_CORES-1:0]        val_data;
  logic [DATA_W-1:0]           mem_dat;
  logic                        busy;
  logic [ID_W-1:0]             grant_id;

  int checks = 0;
  int errors = 0;
  int grantLog[$];

  shared_mem_ctrl #(
    .NUM_CORES(NUM_CORES), .ID_W(ID_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)
  ) dut (
    .clk(clk), .reset(reset), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .val_data(val_data),
    .mem_dat(mem_dat), .busy(busy), .grant_id(grant_id)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
    checks++;
    if (actual !== required) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, actual, required, $time);
    end
  endtask

  task automatic applyStimulus(input int core, input logic we, input logic [ADDR_W-1:0] addr,
                               input logic [DATA_W-1:0] data, input logic req);
    mem_we[core]                       = we;
    mem_addr[core*ADDR_W +: ADDR_W]    = addr;
    mem_wdata[core*DATA_W +: DATA_W]   = data;
    mem_req[core]                      = req;
  endtask

  // Reference model: who owns the port, how long since the grant, and a plain memory.
  int                owner = -1;
  int                age = 0;
  int                rr = 0;
  int                cand = 0;
  logic              mWe;
  logic [ADDR_W-1:0] mAddr;
  logic [DATA_W-1:0] mData;
  logic [DATA_W-1:0] modelMem [int];
  logic [NUM_CORES-1:0] expVal = '0;
  logic [DATA_W-1:0]    expDat = '0;
  int                   expGid = 0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      owner = -1; age = 0; rr = 0;
      expVal = '0; expDat = '0; expGid = 0;
    end else if (owner < 0) begin
      expVal = '0;
      for (int i = 0; i < NUM_CORES; i++) begin
        cand = (rr + i) % NUM_CORES;
        if (owner < 0 && mem_req[cand]) begin
          owner  = cand;
          age    = 0;
          mWe    = mem_we[cand];
          mAddr  = mem_addr[cand*ADDR_W +: ADDR_W];
          mData  = mem_wdata[cand*DATA_W +: DATA_W];
          rr     = (cand + 1) % NUM_CORES;
          expGid = cand;
        end
      end
    end else begin
      age++;
      if (age == 1) begin
        if (mWe) modelMem[int'(mAddr)] = mData;
        else     expDat = modelMem[int'(mAddr)];
        expVal = NUM_CORES'(1) << owner;
      end else begin
        expVal = '0;
        if (!mem_req[owner]) owner = -1;
      end
    end
    #1;
    checkOutput("model_val_data", 32'(val_data), 32'(expVal));
    checkOutput("model_busy", 32'(busy), (owner >= 0) ? 32'd1 : 32'd0);
    checkOutput("model_grant_id", 32'(grant_id), 32'(expGid));
    checkOutput("model_mem_dat", 32'(mem_dat), 32'(expDat));
  end

  task automatic waitVal(input int core, output logic [DATA_W-1:0] rdata, output int latency);
    bit seen = 0;
    rdata   = '0;
    latency = 0;
    for (int n = 1; n <= 60 && !seen; n++) begin
      @(negedge clk);
      if (val_data[core]) begin
        seen    = 1;
        latency = n;
        rdata   = mem_dat;
        grantLog.push_back(core);
      end
    end
    if (!seen) checkOutput($sformatf("timeout_core%0d", core), 32'd0, 32'd1);
  endtask

  task automatic doTransfer(input int core, input logic we, input logic [ADDR_W-1:0] addr,
                            input logic [DATA_W-1:0] data, output logic [DATA_W-1:0] rdata,
                            output int latency);
    applyStimulus(core, we, addr, data, 1'b1);
    waitVal(core, rdata, latency);
    mem_req[core] = 1'b0;
    @(negedge clk);
    checkOutput($sformatf("pulse_width_core%0d", core), 32'(val_data[core]), 32'd0);
  endtask

  task automatic coreLoop(input int core, input int count, input int base);
    logic [DATA_W-1:0] rd;
    int lat;
    for (int k = 0; k < count; k++) begin
      doTransfer(core, 1'b1, ADDR_W'(12'h200 + core), DATA_W'(base + k), rd, lat);
    end
  endtask

  task automatic doReset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_grant_id", 32'(grant_id), 32'd0);
    checkOutput("reset_val_data", 32'(val_data), 32'd0);
    checkOutput("reset_mem_dat", 32'(mem_dat), 32'd0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic checkOrder(input string name, input int expOrder[$]);
    checkOutput({name, "_count"}, 32'(grantLog.size()), 32'(expOrder.size()));
    for (int i = 0; i < expOrder.size(); i++) begin
      checkOutput($sformatf("%s_%0d", name, i),
                  (i < grantLog.size()) ? 32'(grantLog[i]) : 32'hFFFF_FFFF, 32'(expOrder[i]));
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=running required=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [DATA_W-1:0] rd;
    int lat;
    mem_req = '0; mem_we = '0; mem_addr = '0; mem_wdata = '0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("por_busy", 32'(busy), 32'd0);
    checkOutput("por_mem_dat", 32'(mem_dat), 32'd0);
    reset = 1'b0;

    // Store then load from one core; store leaves mem_dat alone.
    doTransfer(0, 1'b1, 12'h123, 8'hA5, rd, lat);
    checkOutput("t1_store_latency", 32'(lat), 32'd2);
    checkOutput("t1_store_mem_dat", 32'(rd), 32'd0);
    doTransfer(0, 1'b0, 12'h123, 8'h00, rd, lat);
    checkOutput("t1_load_latency", 32'(lat), 32'd2);
    checkOutput("t1_load_data", 32'(rd), 32'hA5);

    // Three simultaneous requesters after reset, each asking twice.
    doReset();
    grantLog.delete();
    fork
      coreLoop(0, 2, 8'h40);
      coreLoop(2, 2, 8'h60);
      coreLoop(3, 2, 8'h70);
    join
    checkOrder("t2_order", '{0, 2, 3, 0, 2, 3});

    // Two cores hammering the port must alternate.
    grantLog.delete();
    fork
      coreLoop(0, 3, 8'h10);
      coreLoop(1, 3, 8'h20);
    join
    checkOrder("t3_order", '{0, 1, 0, 1, 0, 1});

    // Owner holds mem_req past its pulse; the waiting core is locked out.
    applyStimulus(0, 1'b1, 12'h300, 8'h77, 1'b1);
    waitVal(0, rd, lat);
    applyStimulus(1, 1'b1, 12'h301, 8'h88, 1'b1);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checkOutput($sformatf("t4_hold_busy_%0d", c), 32'(busy), 32'd1);
      checkOutput($sformatf("t4_hold_val_%0d", c), 32'(val_data), 32'd0);
      checkOutput($sformatf("t4_hold_gid_%0d", c), 32'(grant_id), 32'd0);
    end
    mem_req[0] = 1'b0;
    @(negedge clk);
    checkOutput("t4_idle_busy", 32'(busy), 32'd0);
    @(negedge clk);
    checkOutput("t4_grant1_busy", 32'(busy), 32'd1);
    checkOutput("t4_grant1_gid", 32'(grant_id), 32'd1);
    waitVal(1, rd, lat);
    checkOutput("t4_core1_latency", 32'(lat), 32'd1);
    mem_req[1] = 1'b0;
    @(negedge clk);

    // Reset lands between grant and access: the store must be dropped.
    doTransfer(2, 1'b1, 12'h010, 8'h11, rd, lat);
    applyStimulus(2, 1'b1, 12'h010, 8'h3C, 1'b1);
    @(posedge clk);
    #1;
    checkOutput("t5_granted_busy", 32'(busy), 32'd1);
    checkOutput("t5_granted_gid", 32'(grant_id), 32'd2);
    #1 reset = 1'b1;
    #1;
    checkOutput("t5_rst_busy", 32'(busy), 32'd0);
    checkOutput("t5_rst_val", 32'(val_data), 32'd0);
    checkOutput("t5_rst_gid", 32'(grant_id), 32'd0);
    checkOutput("t5_rst_mem_dat", 32'(mem_dat), 32'd0);
    mem_req[2] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    doTransfer(1, 1'b0, 12'h010, 8'h00, rd, lat);
    checkOutput("t5_load_after_reset", 32'(rd), 32'h11);

    // Address extremes from different cores, no aliasing.
    doTransfer(1, 1'b1, 12'h000, 8'h5A, rd, lat);
    doTransfer(3, 1'b1, 12'hFFF, 8'hC3, rd, lat);
    doTransfer(0, 1'b0, 12'h000, 8'h00, rd, lat);
    checkOutput("t6_load_low", 32'(rd), 32'h5A);
    doTransfer(2, 1'b0, 12'hFFF, 8'h00, rd, lat);
    checkOutput("t6_load_high", 32'(rd), 32'hC3);

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
